// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle adder/subtractor. A WIDTH-bit operation is split into
// K = WIDTH/DIGIT digits of DIGIT bits each. The digits are processed one per
// clock, least significant first, through a DIGIT-bit ripple of full-adder
// cells and a single carry register. Subtraction is done as a + ~b + 1.
// WIDTH must be at least 2 and a whole multiple of DIGIT.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_start     operation request, sampled only while idle
//   i_sub       0 = add, 1 = subtract (sampled with i_start)
//   i_a, i_b    operands (sampled with i_start)
//   i_cin       carry-in for add, ignored for subtract
//   o_busy      high while an operation is running
//   o_done      one-cycle pulse when o_sum/o_cout/o_overflow update
//   o_sum       result, held until the next completion
//   o_cout      carry out of the MSB (for subtract: 1 = no borrow)
//   o_overflow  signed two's-complement overflow of the last result
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int K  = WIDTH / DIGIT;
  // Keep the counter at least one bit wide so K=1 still elaborates.
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(K - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_dsum;
  logic [WIDTH-1:0] w_psum_next;

  // Digit ripple: w_c[gi] is the carry into bit gi of the current digit.
  assign w_c[0] = r_carry;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      assign w_dsum[gi]  = r_a[gi] ^ r_b[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (r_a[gi] & r_b[gi]) | (w_c[gi] & (r_a[gi] ^ r_b[gi]));
    end
  endgenerate

  // New digit enters from the MSB side; after K shifts digit 0 sits at the
  // bottom and the register holds the complete result.
  assign w_psum_next = (r_psum >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_psum     <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            // Subtract becomes a + ~b + 1: invert B and force the carry-in.
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub ? 1'b1 : i_cin;
            r_psum  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_c[DIGIT];
          r_psum  <= w_psum_next;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_DIGIT) begin
            r_sum      <= w_psum_next;
            r_cout     <= w_c[DIGIT];
            // Signed overflow: carry into the MSB differs from carry out of it.
            r_overflow <= w_c[DIGIT-1] ^ w_c[DIGIT];
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_sum      = r_sum;
  assign o_cout     = r_cout;
  assign o_overflow = r_overflow;

endmodule
